// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: captures uart_rx frames into a first-word-fall-through FIFO with watermark irq and sticky overrun.
// Define UART_RX_CTRL_TIMEOUT_EN to enable the character-timeout counter driving timeout_o.
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_i,
    input  logic [31:0] rx_data_i,
    input  logic        parity_error_i,
    output logic        host_read_data_o,
    input  logic        rd_en_i,
    output logic [8:0]  rd_data_o,
    output logic [4:0]  level_o,
    output logic        empty_o,
    output logic        full_o,
    input  logic [4:0]  threshold_i,
    output logic        irq_o,
    output logic        overrun_o,
    input  logic        clr_overrun_i,
    output logic        timeout_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, CAPTURE, ACK, WAIT_CLR} state_t;
    state_t state, state_n;
    logic [8:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic push, accept, pop;
    logic unused_data;

    assign unused_data = ^rx_data_i[31:8];
    assign push = state == CAPTURE;
    assign pop = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign accept = push && (!full_o || rd_en_i);
    assign empty_o = level_o == 5'd0;
    assign full_o = level_o == 5'(DEPTH);
    assign irq_o = threshold_i != 5'd0 && level_o >= threshold_i;
    assign rd_data_o = empty_o ? 9'h000 : mem[rptr];
    assign host_read_data_o = state == ACK;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = rx_done_i ? CAPTURE : IDLE;
            CAPTURE:  state_n = ACK;
            ACK:      state_n = WAIT_CLR;
            default:  state_n = rx_done_i ? WAIT_CLR : IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wptr <= '0;
            rptr <= '0;
            level_o <= '0;
            overrun_o <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            level_o <= level_o + 5'(accept) - 5'(pop);
            if (push && !accept) overrun_o <= 1'b1;
            else if (clr_overrun_i) overrun_o <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) mem[wptr] <= {parity_error_i, rx_data_i[7:0]};
    end

`ifdef UART_RX_CTRL_TIMEOUT_EN
    logic [15:0] idle_cnt;

    // Counter saturates at TIMEOUT_CYCLES so timeout_o stays set until activity or empty
    always_ff @(posedge clk) begin
        if (reset || accept || pop || empty_o) begin
            idle_cnt <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (idle_cnt != 16'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + 16'd1;
            if (idle_cnt == 16'(TIMEOUT_CYCLES - 1)) timeout_o <= 1'b1;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized scoreboard bench for uart_rx_ctrl against a queue-based FIFO model.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset, rx_done_i, parity_error_i, rd_en_i, clr_overrun_i;
    logic [31:0] rx_data_i;
    logic [4:0] threshold_i;
    logic host_read_data_o, empty_o, full_o, irq_o, overrun_o, timeout_o;
    logic [8:0] rd_data_o;
    logic [4:0] level_o;
    int checks = 0, errors = 0;
    logic [8:0] exp_q[$];
    int mlvl = 0;
    bit movr = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .rx_done_i(rx_done_i), .rx_data_i(rx_data_i),
        .parity_error_i(parity_error_i), .host_read_data_o(host_read_data_o),
        .rd_en_i(rd_en_i), .rd_data_o(rd_data_o), .level_o(level_o),
        .empty_o(empty_o), .full_o(full_o), .threshold_i(threshold_i), .irq_o(irq_o),
        .overrun_o(overrun_o), .clr_overrun_i(clr_overrun_i), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every real pop must present the oldest expected entry
    always @(negedge clk) begin
        if (!reset && rd_en_i && !empty_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_data: DUT popped %0h but model FIFO is empty", rd_data_o);
            end else chk("pop_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
        end
    end

    task automatic status(input string tag);
        @(negedge clk);
        chk({tag, ".level"}, 32'(level_o), 32'(mlvl));
        chk({tag, ".empty"}, 32'(empty_o), 32'(mlvl == 0));
        chk({tag, ".full"}, 32'(full_o), 32'(mlvl == DEPTH));
        chk({tag, ".irq"}, 32'(irq_o), 32'(threshold_i != 0 && mlvl >= int'(threshold_i)));
        chk({tag, ".overrun"}, 32'(overrun_o), 32'(movr));
        if (mlvl == 0) chk({tag, ".head"}, 32'(rd_data_o), 32'd0);
        else chk({tag, ".head"}, 32'(rd_data_o), 32'(exp_q[0]));
`ifndef UART_RX_CTRL_TIMEOUT_EN
        chk({tag, ".timeout"}, 32'(timeout_o), 32'd0);
`endif
        tick;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input bit pop_same, input int hold);
        bit popping, acc;
        rx_data_i = {24'($urandom()), d};
        parity_error_i = p;
        rx_done_i = 1'b1;
        tick;
        rd_en_i = pop_same;
        popping = pop_same && mlvl > 0;
        acc = mlvl < DEPTH || popping;
        if (acc) exp_q.push_back({p, d});
        else movr = 1;
        mlvl += int'(acc) - int'(popping);
        tick;
        rd_en_i = 1'b0;
        @(negedge clk);
        chk("ack_high", 32'(host_read_data_o), 32'd1);
        tick;
        repeat (hold) tick;
        rx_done_i = 1'b0;
        @(negedge clk);
        chk("ack_low", 32'(host_read_data_o), 32'd0);
        tick;
        status("frame");
    endtask

    task automatic pop_one;
        rd_en_i = 1'b1;
        if (mlvl > 0) mlvl--;
        tick;
        rd_en_i = 1'b0;
        status("pop");
    endtask

    task automatic clr_ovr;
        clr_overrun_i = 1'b1;
        movr = 0;
        tick;
        clr_overrun_i = 1'b0;
        status("clr");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1; rx_done_i = 0; rx_data_i = 0; parity_error_i = 0;
        rd_en_i = 0; clr_overrun_i = 0; threshold_i = 0;
        tick; tick;
        reset = 0;
        @(negedge clk);
        chk("reset_ack", 32'(host_read_data_o), 32'd0);
        tick;
        status("reset");

        send_frame(8'h5A, 1'b0, 0, 0);
        chk("basic_head", 32'(rd_data_o), 32'h05A);
        chk("basic_level", 32'(level_o), 32'd1);
        pop_one();

        for (int i = 0; i < 5; i++) send_frame(8'(i * 17 + 1), 1'(i), 0, 1);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_overrun", 32'(overrun_o), 32'd1);
        clr_ovr();
        chk("clr_overrun", 32'(overrun_o), 32'd0);

        send_frame(8'hC3, 1'b1, 1, 0);
        chk("full_push_pop_overrun", 32'(overrun_o), 32'd0);
        chk("full_push_pop_level", 32'(level_o), 32'd4);
        repeat (4) pop_one();
        pop_one();
        chk("pop_empty_level", 32'(level_o), 32'd0);

        threshold_i = 5'd2;
        send_frame(8'h11, 1'b0, 0, 0);
        send_frame(8'h22, 1'b1, 0, 2);
        chk("irq_set", 32'(irq_o), 32'd1);
        pop_one();
        chk("irq_clear", 32'(irq_o), 32'd0);
        pop_one();

        repeat (3) send_frame(8'($urandom()), 1'b0, 0, 0);
        rx_data_i = 32'h0000_00E7;
        rx_done_i = 1'b1;
        tick;
        tick;
        reset = 1'b1;
        @(negedge clk);
        chk("pre_reset_ack", 32'(host_read_data_o), 32'd1);
        tick;
        reset = 1'b0;
        rx_done_i = 1'b0;
        exp_q.delete();
        mlvl = 0;
        movr = 0;
        @(negedge clk);
        chk("reset_ack_drop", 32'(host_read_data_o), 32'd0);
        chk("reset_level", 32'(level_o), 32'd0);
        chk("reset_empty", 32'(empty_o), 32'd1);
        tick;
        status("post_reset");

        rx_data_i = 32'h0000_0096;
        parity_error_i = 1'b1;
        rx_done_i = 1'b1;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("capture_reset_level", 32'(level_o), 32'd0);
        tick;
        tick;
        exp_q.push_back(9'h196);
        mlvl = 1;
        @(negedge clk);
        chk("recapture_ack", 32'(host_read_data_o), 32'd1);
        chk("recapture_head", 32'(rd_data_o), 32'h196);
        tick;
        rx_done_i = 1'b0;
        parity_error_i = 1'b0;
        tick;
        status("recapture");
        pop_one();

`ifdef UART_RX_CTRL_TIMEOUT_EN
        begin
            int n = 0;
            send_frame(8'h3C, 1'b0, 0, 0);
            while (!timeout_o && n < 30) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_set", 32'(timeout_o), 32'd1);
            tick;
            pop_one();
            chk("timeout_clear", 32'(timeout_o), 32'd0);
        end
`endif

        for (int it = 0; it < 300; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 5) send_frame(8'($urandom()), 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 2));
            else if (r < 8) pop_one();
            else if (r == 8) clr_ovr();
            else begin
                threshold_i = 5'($urandom_range(0, 5));
                tick;
                status("thresh");
            end
        end
        while (mlvl > 0) pop_one();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
